// File: rtl/ex_wb_forward_pipe.sv
// ex_wb_forward_pipe
//   Back end of the operand path. Each EX-stage result is captured into a MEM register and
//   then a WB register. The WB register drives the register-file write port. The newest
//   in-flight value of a source register is returned to the ALU operand selectors. A
//   load-use hazard raises a one-cycle decode stall request.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid/regwrite/...   EX-stage instruction: valid, writes rd, is a load, rd, result
//   mem_rdata               load data for the instruction currently in MEM
//   stall                   holds the MEM register and inserts a bubble into WB
//   flush                   kills the instruction entering MEM
//   id_rs1, id_rs2          source registers of the instruction entering EX
//   wb_we/wb_addr/wb_data   register-file write port
//   fwd_sel1/2, fwd_data1/2 forwarding select (00 none, 01 MEM, 10 WB) and operand value
//   load_use_stall          a source register depends on a load currently in MEM
module ex_wb_forward_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  ex_regwrite,
   input  logic                  ex_memread,
   input  logic [ADDR_WIDTH-1:0] ex_rd,
   input  logic [DATA_WIDTH-1:0] ex_result,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] id_rs1,
   input  logic [ADDR_WIDTH-1:0] id_rs2,
   output logic                  wb_we,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [1:0]            fwd_sel1,
   output logic [1:0]            fwd_sel2,
   output logic [DATA_WIDTH-1:0] fwd_data1,
   output logic [DATA_WIDTH-1:0] fwd_data2,
   output logic                  load_use_stall
);

   logic                  m_valid_q, m_valid_d;
   logic                  m_memread_q, m_memread_d;
   logic [ADDR_WIDTH-1:0] m_rd_q, m_rd_d;
   logic [DATA_WIDTH-1:0] m_result_q, m_result_d;
   logic                  w_valid_q, w_valid_d;
   logic [ADDR_WIDTH-1:0] w_rd_q, w_rd_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

   // MEM capture: flush wins over stall. Writes to x0 are dropped here, so neither a
   // forward nor a register-file write can ever target x0.
   always_comb begin
      m_valid_d   = m_valid_q;
      m_memread_d = m_memread_q;
      m_rd_d      = m_rd_q;
      m_result_d  = m_result_q;
      if (flush) begin
         m_valid_d = 1'b0;
      end else if (!stall) begin
         m_valid_d   = ex_valid & ex_regwrite & (ex_rd != '0);
         m_memread_d = ex_memread;
         m_rd_d      = ex_rd;
         m_result_d  = ex_result;
      end
   end

   // WB capture: a stall leaves MEM in place, so WB takes a bubble to avoid a double write.
   always_comb begin
      w_valid_d = 1'b0;
      w_rd_d    = w_rd_q;
      w_data_d  = w_data_q;
      if (!stall) begin
         w_valid_d = m_valid_q;
         w_rd_d    = m_rd_q;
         w_data_d  = m_memread_q ? mem_rdata : m_result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q   <= 1'b0;
         m_memread_q <= 1'b0;
         m_rd_q      <= '0;
         m_result_q  <= '0;
         w_valid_q   <= 1'b0;
         w_rd_q      <= '0;
         w_data_q    <= '0;
      end else begin
         m_valid_q   <= m_valid_d;
         m_memread_q <= m_memread_d;
         m_rd_q      <= m_rd_d;
         m_result_q  <= m_result_d;
         w_valid_q   <= w_valid_d;
         w_rd_q      <= w_rd_d;
         w_data_q    <= w_data_d;
      end
   end

   assign wb_we   = w_valid_q;
   assign wb_addr = w_rd_q;
   assign wb_data = w_data_q;

   // A load in MEM has no data yet, so it is skipped and the operand falls through to WB.
   always_comb begin
      fwd_sel1  = 2'b00;
      fwd_data1 = '0;
      if (id_rs1 != '0) begin
         if (m_valid_q && !m_memread_q && (m_rd_q == id_rs1)) begin
            fwd_sel1  = 2'b01;
            fwd_data1 = m_result_q;
         end else if (w_valid_q && (w_rd_q == id_rs1)) begin
            fwd_sel1  = 2'b10;
            fwd_data1 = w_data_q;
         end
      end
   end

   always_comb begin
      fwd_sel2  = 2'b00;
      fwd_data2 = '0;
      if (id_rs2 != '0) begin
         if (m_valid_q && !m_memread_q && (m_rd_q == id_rs2)) begin
            fwd_sel2  = 2'b01;
            fwd_data2 = m_result_q;
         end else if (w_valid_q && (w_rd_q == id_rs2)) begin
            fwd_sel2  = 2'b10;
            fwd_data2 = w_data_q;
         end
      end
   end

   assign load_use_stall = m_valid_q & m_memread_q & (m_rd_q != '0) &
                           ((m_rd_q == id_rs1) | (m_rd_q == id_rs2));

endmodule

// File: tb/tb_ex_wb_forward_pipe.sv
// tb_ex_wb_forward_pipe
//   Directed scenarios plus randomized traffic, checked against an instruction-level model
//   that tracks which instruction sits in MEM and in WB.
module tb_ex_wb_forward_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_regwrite, ex_memread, stall, flush;
   logic [4:0]  ex_rd, id_rs1, id_rs2;
   logic [31:0] ex_result, mem_rdata;
   logic        wb_we, load_use_stall;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, fwd_data1, fwd_data2;
   logic [1:0]  fwd_sel1, fwd_sel2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_wb_forward_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .ex_result(ex_result), .mem_rdata(mem_rdata),
      .stall(stall), .flush(flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .load_use_stall(load_use_stall)
   );

   // An in-flight instruction as the model sees it: does it write a register, is it a
   // load still waiting for data, which register, and which value.
   typedef struct {
      bit          writes;
      bit          is_load;
      logic [4:0]  rd;
      logic [31:0] value;
   } instr_t;

   instr_t in_mem, in_wb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t empty_instr();
      instr_t e;
      e.writes = 0; e.is_load = 0; e.rd = '0; e.value = '0;
      return e;
   endfunction

   // Newest producer of rs: a completed value in MEM beats one in WB; loads in MEM have
   // no value yet.
   task automatic ref_operand(input logic [4:0] rs, output logic [1:0] sel,
                              output logic [31:0] val);
      sel = 2'd0; val = '0;
      if (rs == 0) return;
      if (in_mem.writes && !in_mem.is_load && in_mem.rd == rs) begin
         sel = 2'd1; val = in_mem.value;
      end else if (in_wb.writes && in_wb.rd == rs) begin
         sel = 2'd2; val = in_wb.value;
      end
   endtask

   task automatic compare_model();
      logic [1:0]  s1, s2;
      logic [31:0] d1, d2;
      bit          lu;
      ref_operand(id_rs1, s1, d1);
      ref_operand(id_rs2, s2, d2);
      lu = in_mem.writes && in_mem.is_load && (in_mem.rd == id_rs1 || in_mem.rd == id_rs2);
      check("wb_we", {31'b0, wb_we}, {31'b0, in_wb.writes});
      if (in_wb.writes) begin
         check("wb_addr", {27'b0, wb_addr}, {27'b0, in_wb.rd});
         check("wb_data", wb_data, in_wb.value);
      end
      check("fwd_sel1", {30'b0, fwd_sel1}, {30'b0, s1});
      check("fwd_data1", fwd_data1, d1);
      check("fwd_sel2", {30'b0, fwd_sel2}, {30'b0, s2});
      check("fwd_data2", fwd_data2, d2);
      check("load_use", {31'b0, load_use_stall}, {31'b0, lu});
   endtask

   // Drive one cycle's inputs away from the clock edge, then compare against the model.
   task automatic set_in(input bit v, input bit rw, input bit mr, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] rdata, input bit st,
                         input bit fl, input logic [4:0] rs1, input logic [4:0] rs2);
      @(negedge clk);
      ex_valid = v; ex_regwrite = rw; ex_memread = mr; ex_rd = rd; ex_result = res;
      mem_rdata = rdata; stall = st; flush = fl; id_rs1 = rs1; id_rs2 = rs2;
      #1;
      compare_model();
   endtask

   // Clock edge: advance the model by one instruction slot.
   task automatic adv();
      instr_t next_wb;
      @(posedge clk);
      next_wb = in_wb;
      if (stall) begin
         next_wb.writes = 0;
      end else begin
         next_wb = in_mem;
         next_wb.is_load = 0;
         if (in_mem.is_load) next_wb.value = mem_rdata;
      end
      if (flush) begin
         in_mem.writes = 0;
      end else if (!stall) begin
         in_mem.writes  = ex_valid && ex_regwrite && ex_rd != 0;
         in_mem.is_load = ex_memread;
         in_mem.rd      = ex_rd;
         in_mem.value   = ex_result;
      end
      in_wb = next_wb;
   endtask

   task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
      set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, rs1, rs2);
   endtask

   initial begin
      in_mem = empty_instr();
      in_wb  = empty_instr();
      ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_rd = 0; ex_result = 0;
      mem_rdata = 0; stall = 0; flush = 0; id_rs1 = 0; id_rs2 = 0;
      rst_n = 0;
      #12;
      rst_n = 1;
      idle(0, 0);
      check("reset_wb_we", {31'b0, wb_we}, 32'd0);
      adv();

      // Back-to-back: MEM forward, then WB forward and the write two cycles after capture.
      set_in(1, 1, 0, 5'd5, 32'h11, 32'h0, 0, 0, 0, 0); adv();
      set_in(1, 1, 0, 5'd6, 32'h22, 32'h0, 0, 0, 5, 0);
      check("b2b_sel1", {30'b0, fwd_sel1}, 32'd1);
      check("b2b_data1", fwd_data1, 32'h11);
      adv();
      idle(0, 5);
      check("b2b_sel2", {30'b0, fwd_sel2}, 32'd2);
      check("b2b_data2", fwd_data2, 32'h11);
      check("b2b_addr", {27'b0, wb_addr}, 32'd5);
      check("b2b_wdata", wb_data, 32'h11);
      adv();

      // Priority: newer x7 in MEM wins over older x7 in WB.
      set_in(1, 1, 0, 5'd7, 32'hA, 32'h0, 0, 0, 0, 0); adv();
      set_in(1, 1, 0, 5'd7, 32'hB, 32'h0, 0, 0, 0, 0); adv();
      idle(7, 0);
      check("prio_sel1", {30'b0, fwd_sel1}, 32'd1);
      check("prio_data1", fwd_data1, 32'hB);
      adv();

      // Load-use: stall request while the load is in MEM, then WB forward of load data.
      set_in(1, 1, 1, 5'd3, 32'h100, 32'h0, 0, 0, 0, 0); adv();
      set_in(0, 0, 0, 5'd0, 32'h0, 32'hDEAD, 0, 0, 0, 3);
      check("lu_stall", {31'b0, load_use_stall}, 32'd1);
      adv();
      idle(0, 3);
      check("lu_sel2", {30'b0, fwd_sel2}, 32'd2);
      check("lu_data2", fwd_data2, 32'hDEAD);
      check("lu_wdata", wb_data, 32'hDEAD);
      adv();

      // Stall+flush kills x9; stall alone gives a single write of the held instruction.
      set_in(1, 1, 0, 5'd8, 32'h88, 32'h0, 0, 0, 0, 0); adv();
      set_in(1, 1, 0, 5'd9, 32'h99, 32'h0, 1, 1, 0, 0); adv();
      idle(9, 9);
      check("sf_bubble", {31'b0, wb_we}, 32'd0);
      adv();
      idle(9, 9);
      check("sf_no_x9", {31'b0, wb_we}, 32'd0);
      adv();
      set_in(1, 1, 0, 5'd10, 32'hAA, 32'h0, 0, 0, 0, 0); adv();
      set_in(1, 1, 0, 5'd11, 32'hBB, 32'h0, 1, 0, 0, 0); adv();
      idle(0, 0);
      check("st_bubble", {31'b0, wb_we}, 32'd0);
      adv();
      idle(0, 0);
      check("st_write", {31'b0, wb_we}, 32'd1);
      check("st_addr", {27'b0, wb_addr}, 32'd10);
      adv();
      idle(0, 0);
      check("st_once", {31'b0, wb_we}, 32'd0);
      adv();

      // x0 destination is never written nor forwarded.
      set_in(1, 1, 0, 5'd0, 32'h55, 32'h0, 0, 0, 0, 0);
      check("x0_sel1", {30'b0, fwd_sel1}, 32'd0);
      adv();
      idle(0, 0); adv();
      idle(0, 0);
      check("x0_we", {31'b0, wb_we}, 32'd0);
      adv();

      // Asynchronous reset with both stages occupied.
      set_in(1, 1, 0, 5'd4, 32'h44, 32'h0, 0, 0, 0, 0); adv();
      set_in(1, 1, 0, 5'd12, 32'hCC, 32'h0, 0, 0, 0, 0); adv();
      @(negedge clk);
      ex_valid = 0; id_rs1 = 12; id_rs2 = 4;
      #2 rst_n = 0;
      #1;
      in_mem = empty_instr();
      in_wb  = empty_instr();
      check("rst_we", {31'b0, wb_we}, 32'd0);
      check("rst_addr", {27'b0, wb_addr}, 32'd0);
      check("rst_wdata", wb_data, 32'd0);
      check("rst_sel1", {30'b0, fwd_sel1}, 32'd0);
      check("rst_data2", fwd_data2, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         idle(12, 4);
         check("rst_after", {31'b0, wb_we}, 32'd0);
         adv();
      end

      // Randomized traffic on a small register window so hazards are frequent.
      for (int i = 0; i < 600; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         adv();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
